bcd_mod_counter: RTL
====================

# bcd_mod_counter

Parametrised two-digit BCD counter with an internal tick prescaler, run/pause enable, up/down direction, synchronous preset load and a one-cycle wrap pulse for cascading. It generalises the fixed 0–59 seconds counter to any modulus 2–100 and any tick rate. It sits between the board clock and the TM1638 display driver, and chains with further instances via `wrap` for mm:ss or hh:mm displays.

## Interface
- `TICK_DIV`, default 25_000_000: clock cycles per count step; legal range ≥ 1.
- `MOD`, default 60: counter modulus; count range 00 to MOD-1; legal range 2..100.
- `clk` input, 1 bit: single clock; all logic on its rising edge.
- `reset` input, 1 bit: synchronous, active-high.
- `en` input, 1 bit: 1 = run, 0 = pause. Prescaler and digits hold while paused.
- `dir` input, 1 bit: 0 = count up, 1 = count down.
- `load` input, 1 bit: synchronous preset load, one cycle.
- `d1` input, 4 bits: preset tens digit.
- `d0` input, 4 bits: preset units digit.
- `q1` output, 4 bits: tens digit, BCD.
- `q0` output, 4 bits: units digit, BCD.
- `tick` output, 1 bit: internal step pulse, exported for chaining and debug.
- `wrap` output, 1 bit: one-cycle pulse on wrap-around in either direction.

## Operation
- **Prescaler** `pcnt`, ceil(log2(TICK_DIV)) bits:
  - When `en`=1, counts 0..TICK_DIV-1 and wraps.
  - `tick` is combinational, high when `en`=1 and `pcnt`=TICK_DIV-1.
  - If TICK_DIV=1, `tick` equals `en`.
- **Step** occurs on every cycle with `tick`=1.
  - Up, units < 9 and value ≠ MOD-1: units+1.
  - Up, units = 9: units→0, tens+1.
  - Up, value = MOD-1: →00, `wrap`=1.
  - Down, units > 0: units-1.
  - Down, units = 0 and value ≠ 00: units→9, tens-1.
  - Down, value = 00: →MOD-1 (tens=(MOD-1)/10, units=(MOD-1)%10), `wrap`=1.
- **Load:**
  - Digits take `d1`/`d0`; `pcnt` clears to 0; `wrap` stays 0.
  - The preset is invalid if either digit > 9 or 10·d1+d0 ≥ MOD. An invalid preset loads 00.
- **Priority:** reset > load > step > hold.
  - Load in the same cycle as a tick suppresses that step.
- `dir` is sampled only on tick cycles. Changing it mid-period takes effect at the next tick.
- Digit arithmetic is per-digit 4-bit BCD. No binary intermediate is stored.

## Timing
- Reset values: `q1`=0, `q0`=0, `wrap`=0, `pcnt`=0, so `tick`=0.
- Reset mid-period discards the prescaler phase.
- First step occurs TICK_DIV enabled cycles after reset or load.
- Digits update at the rising edge that ends the `tick` cycle.
- `wrap` is registered. It is high for exactly the one cycle after that edge, coincident with the first cycle showing the wrapped value.
- Pause: deasserting `en` freezes `pcnt`. Resuming continues from the stored phase, so total enabled cycles between steps is always TICK_DIV.
- `load` takes effect at the next edge. The loaded value is visible the following cycle.
- Direction reversal at a boundary:
  - Up step from MOD-1 gives 00 with `wrap`.
  - A following down step from 00 gives MOD-1 with `wrap` again.

## Configuration
- **`BCD_DOWN_EN`** defined:
  - `dir` input is present.
  - Down-counting and borrow wrap are implemented as above.
- **`BCD_DOWN_EN`** undefined:
  - `dir` port is still declared but ignored.
  - The counter is up-only.
  - Down-step logic is not synthesised.

## Structure
- **Package `bcd_pkg`:**
  - Constant `BCD_MAX`=4'd9.
  - Function `bcd_valid(d1, d0, mod)`.
  - Functions `top_tens(mod)` and `top_units(mod)`.
- **Sub-module `tick_prescaler`**, parameter TICK_DIV:
  - Ports: `clk`, `reset`, `en`, `clr`, `tick`.
  - Holds `pcnt`; `clr` is driven by `load`.
- The top module holds the digit registers, the step/load mux and the `wrap` register.

## Test plan
All cases use TICK_DIV=4.
- Reset then `en`=1, MOD=60, up: `tick` every 4 cycles. `q1:q0` runs 00,01…09,10…59,00. `wrap` is high one cycle after 59→00, and at no other time.
- MOD=24, `dir`=1, load 00: next tick gives 23 with `wrap`=1, then 22, 21.
- Load presets:
  - 7,B gives 00.
  - 6,0 with MOD=60 gives 00.
  - 4,5 gives 45, and the next step occurs 4 enabled cycles later.
- Pause: with `pcnt`=2, drop `en` for 10 cycles then restore. The step occurs 2 cycles after resume, and `q` is unchanged during the pause.
- Load and tick in the same cycle, preset 30: result is 30 (step suppressed) and `wrap`=0.
- Assert `reset` at 58 mid-period: next cycle shows 00, `wrap`=0; the first step comes 4 enabled cycles later. With `BCD_DOWN_EN` undefined and `dir`=1, the counter still counts up.

Source files
------------

// File: rtl/bcd_mod_counter_pkg.sv
// bcd_pkg: shared definitions for the two-digit BCD modulus counter.
//   BCD_MAX              largest legal BCD digit
//   op_e                 digit-register update selector (hold/load/up/down)
//   top_tens/top_units   BCD digits of MOD-1, the highest count value
//   bcd_valid            preset legality: both digits BCD and value < MOD
// The package holds no logic of its own; it is imported by the counter RTL.
package bcd_pkg;

  localparam logic [3:0] BCD_MAX = 4'd9;

  // Update applied to the digit registers at the next edge.
  typedef enum logic [1:0] {
    OpHold = 2'd0,
    OpLoad = 2'd1,
    OpUp   = 2'd2,
    OpDown = 2'd3
  } op_e;

  // Tens digit of the terminal value MOD-1.
  function automatic logic [3:0] top_tens(input int unsigned mod);
    return 4'((mod - 1) / 10);
  endfunction

  // Units digit of the terminal value MOD-1.
  function automatic logic [3:0] top_units(input int unsigned mod);
    return 4'((mod - 1) % 10);
  endfunction

  // A preset is legal when both digits are BCD and d1:d0 <= MOD-1. The range
  // test compares digit by digit against the terminal value, so no binary
  // form of the preset is ever built.
  function automatic logic bcd_valid(input logic [3:0] d1, input logic [3:0] d0,
                                     input int unsigned mod);
    logic [3:0] tt;
    logic [3:0] tu;
    tt = top_tens(mod);
    tu = top_units(mod);
    if ((d1 > BCD_MAX) || (d0 > BCD_MAX)) begin
      return 1'b0;
    end
    return (d1 < tt) || ((d1 == tt) && (d0 <= tu));
  endfunction

endpackage

// File: rtl/bcd_mod_counter_if.sv
// bcd_mod_counter_if: control and display bus of the BCD modulus counter.
//   en     run (1) / pause (0)
//   dir    0 = count up, 1 = count down (ignored in up-only builds)
//   load   one-cycle synchronous preset load
//   d1/d0  preset tens/units digits
//   q1/q0  current tens/units digits, BCD
//   tick   step pulse from the prescaler (for chaining and debug)
//   wrap   registered one-cycle pulse on wrap-around
// master: the controller driving the counter; slave: the counter itself.
interface bcd_mod_counter_if;

  logic       en;
  logic       dir;
  logic       load;
  logic [3:0] d1;
  logic [3:0] d0;
  logic [3:0] q1;
  logic [3:0] q0;
  logic       tick;
  logic       wrap;

  modport master (
    output en,
    output dir,
    output load,
    output d1,
    output d0,
    input  q1,
    input  q0,
    input  tick,
    input  wrap
  );

  modport slave (
    input  en,
    input  dir,
    input  load,
    input  d1,
    input  d0,
    output q1,
    output q0,
    output tick,
    output wrap
  );

endinterface

// File: rtl/bcd_mod_counter_tick_prescaler.sv
// tick_prescaler: divides the board clock down to the counter step rate.
//   TICK_DIV  clock cycles per step (>= 1)
//   clk_i     clock, rising edge
//   reset_i   synchronous active-high reset, clears the phase
//   en_i      run/pause; the phase is frozen while low
//   clr_i     synchronous phase clear (driven by the counter's preset load)
//   tick_o    combinational step pulse, high when en_i and phase = TICK_DIV-1
module tick_prescaler #(
  parameter int unsigned TICK_DIV = 25_000_000
) (
  input  logic clk_i,
  input  logic reset_i,
  input  logic en_i,
  input  logic clr_i,
  output logic tick_o
);

  if (TICK_DIV < 1) begin : g_bad_div
    $error("tick_prescaler: TICK_DIV must be at least 1");
  end

  // TICK_DIV = 1 would give a zero-width counter; keep one bit that stays 0.
  localparam int unsigned PcntW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PcntW-1:0] PcntMax = PcntW'(TICK_DIV - 1);

  logic [PcntW-1:0] pcnt_q;
  logic [PcntW-1:0] pcnt_d;

  // With TICK_DIV = 1 the phase is always 0 = PcntMax, so tick_o follows en_i.
  assign tick_o = en_i && (pcnt_q == PcntMax);

  always_comb begin
    pcnt_d = pcnt_q;
    if (clr_i) begin
      pcnt_d = '0;
    end else if (en_i) begin
      pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/bcd_mod_counter.sv
// bcd_mod_counter: two-digit BCD counter, modulus MOD (2..100), stepping once
// every TICK_DIV enabled clock cycles, with preset load and a wrap pulse for
// cascading further instances (mm:ss, hh:mm).
// The parameters set the step period (TICK_DIV >= 1 clock cycles) and the
// count range, which runs from 00 up to one below the modulus.
//   clk_i     clock, rising edge
//   reset_i   synchronous active-high reset: digits 00, wrap 0, phase 0
//   bus_io    bcd_mod_counter_if slave: en/dir/load/d1/d0 in, q1/q0/tick/wrap out
// Build option: define BCD_DOWN_EN to implement down-counting with borrow wrap.
// Without it the dir input is accepted but ignored and the counter is up-only.
// Priority at each edge: reset > load > step > hold.
module bcd_mod_counter
  import bcd_pkg::*;
#(
  parameter int unsigned TICK_DIV = 25_000_000,
  parameter int unsigned MOD      = 60
) (
  input logic              clk_i,
  input logic              reset_i,
  bcd_mod_counter_if.slave bus_io
);

  if ((MOD < 2) || (MOD > 100)) begin : g_bad_mod
    $error("bcd_mod_counter: MOD must be in 2..100");
  end

  localparam logic [3:0] TopTens  = top_tens(MOD);
  localparam logic [3:0] TopUnits = top_units(MOD);

  logic       tick;
  logic [3:0] q1_q, q1_d;
  logic [3:0] q0_q, q0_d;
  logic       wrap_q, wrap_d;
  logic       at_top;
  op_e        op;

  // A load restarts the step period, so the next step is a full TICK_DIV
  // enabled cycles after the loaded value appears.
  tick_prescaler #(
    .TICK_DIV(TICK_DIV)
  ) u_prescaler (
    .clk_i  (clk_i),
    .reset_i(reset_i),
    .en_i   (bus_io.en),
    .clr_i  (bus_io.load),
    .tick_o (tick)
  );

  assign at_top = (q1_q == TopTens) && (q0_q == TopUnits);

`ifdef BCD_DOWN_EN
  logic at_zero;
  assign at_zero = (q1_q == 4'd0) && (q0_q == 4'd0);
`else
  logic unused_dir;
  assign unused_dir = bus_io.dir;
`endif

  // Load wins over a coincident tick, which suppresses that step. dir is only
  // looked at on tick cycles.
  always_comb begin
    op = OpHold;
    if (bus_io.load) begin
      op = OpLoad;
    end else if (tick) begin
`ifdef BCD_DOWN_EN
      op = bus_io.dir ? OpDown : OpUp;
`else
      op = OpUp;
`endif
    end
  end

  // Per-digit BCD arithmetic: carry/borrow moves between the digits directly.
  always_comb begin
    q1_d   = q1_q;
    q0_d   = q0_q;
    wrap_d = 1'b0;
    unique case (op)
      OpLoad: begin
        // An out-of-range or non-BCD preset falls back to 00.
        if (bcd_valid(bus_io.d1, bus_io.d0, MOD)) begin
          q1_d = bus_io.d1;
          q0_d = bus_io.d0;
        end else begin
          q1_d = 4'd0;
          q0_d = 4'd0;
        end
      end
      OpUp: begin
        if (at_top) begin
          q1_d   = 4'd0;
          q0_d   = 4'd0;
          wrap_d = 1'b1;
        end else if (q0_q == BCD_MAX) begin
          q1_d = q1_q + 4'd1;
          q0_d = 4'd0;
        end else begin
          q0_d = q0_q + 4'd1;
        end
      end
`ifdef BCD_DOWN_EN
      OpDown: begin
        if (at_zero) begin
          q1_d   = TopTens;
          q0_d   = TopUnits;
          wrap_d = 1'b1;
        end else if (q0_q == 4'd0) begin
          q1_d = q1_q - 4'd1;
          q0_d = BCD_MAX;
        end else begin
          q0_d = q0_q - 4'd1;
        end
      end
`endif
      default: begin
        q1_d   = q1_q;
        q0_d   = q0_q;
        wrap_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      q1_q   <= 4'd0;
      q0_q   <= 4'd0;
      wrap_q <= 1'b0;
    end else begin
      q1_q   <= q1_d;
      q0_q   <= q0_d;
      wrap_q <= wrap_d;
    end
  end

  assign bus_io.q1   = q1_q;
  assign bus_io.q0   = q0_q;
  assign bus_io.wrap = wrap_q;
  assign bus_io.tick = tick;

endmodule
